// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sort-engine arbiter slice:
//   - default table geometry (entries per table, bytes per entry, table width)
//   - arbiter state encoding
//   - entry_slice(): pulls one entry out of a packed table
// Table layout: entry e occupies bits [e*KEY_BYTES*8 +: KEY_BYTES*8]; byte 0 of
// an entry is the suffix index, bytes 1..KEY_BYTES-1 are the sort keys.
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int DEF_STRING_LEN = 8;
  localparam int DEF_KEY_BYTES  = 3;
  localparam int DEF_TBL_W      = DEF_STRING_LEN * DEF_KEY_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    ABORT   = 3'd4
  } arb_state_t;

  function automatic logic [DEF_KEY_BYTES*8-1:0] entry_slice(
    input logic [DEF_TBL_W-1:0] tbl,
    input int                   idx
  );
    return tbl[idx*DEF_KEY_BYTES*8 +: DEF_KEY_BYTES*8];
  endfunction

endpackage

// File: rtl/sort_engine_arbiter_if.sv
// -----------------------------------------------------------------------------
// sort_engine_arbiter_if
// Bundles the requester-side and engine-side signals of the sort arbiter.
//   req          level request per requester, held until done/err
//   req_data     packed tables, requester i at [i*TBL_W +: TBL_W]
//   grant        one-hot owner
//   done / err   one-hot single-cycle completion / timeout pulses
//   result_data  sorted table returned to the winner
//   eng_start    single-cycle start to the sort engine
//   eng_data_in  latched table presented to the engine
//   eng_sorted   engine completion pulse
//   eng_data_out engine result, valid with eng_sorted
//   busy         arbiter not idle
// Modports: slave = arbiter side, master = requesters + engine side.
// -----------------------------------------------------------------------------
interface sort_engine_arbiter_if
  import sort_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TBL_W   = DEF_TBL_W
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*TBL_W-1:0] req_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [NUM_REQ-1:0]       err;
  logic [TBL_W-1:0]         result_data;
  logic                     eng_start;
  logic [TBL_W-1:0]         eng_data_in;
  logic                     eng_sorted;
  logic [TBL_W-1:0]         eng_data_out;
  logic                     busy;

  modport slave (
    input  req, req_data, eng_sorted, eng_data_out,
    output grant, done, err, result_data, eng_start, eng_data_in, busy
  );

  modport master (
    output req, req_data, eng_sorted, eng_data_out,
    input  grant, done, err, result_data, eng_start, eng_data_in, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request bit at or after rr_ptr,
// wrapping around NUM_REQ.
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   IDX_W    highest-priority index this round
//   sel     out  IDX_W    winning index (0 when any=0)
//   onehot  out  NUM_REQ  one-hot of sel (0 when any=0)
//   any     out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import sort_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any
);

  always_comb begin
    int idx;
    idx    = 0;
    sel    = '0;
    any    = 1'b0;
    onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = IDX_W'(idx);
      end
    end
    if (any) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/sort_engine_arbiter.sv
// -----------------------------------------------------------------------------
// sort_engine_arbiter
// Shares one merge-sort engine between NUM_REQ requesters. A round-robin winner
// has its table latched and handed to the engine; the sorted table comes back
// with a one-cycle done pulse, or a one-cycle err pulse if the engine hangs
// past TIMEOUT_CYC cycles in WAIT. All outputs are registered.
// Ports:
//   clk   in  clock
//   rst   in  synchronous, active-high reset
//   bus   sort_engine_arbiter_if.slave (req/req_data in, grant/done/err/
//         result_data/busy out, eng_start/eng_data_in out, eng_sorted/
//         eng_data_out in)
// -----------------------------------------------------------------------------
module sort_engine_arbiter
  import sort_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int STRING_LEN  = DEF_STRING_LEN,
  parameter int KEY_BYTES   = DEF_KEY_BYTES,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  sort_engine_arbiter_if.slave bus
);

  localparam int TBL_W = STRING_LEN * KEY_BYTES * 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = 10;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  arb_state_t          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    sel_q;
  logic [IDX_W-1:0]    pick_sel;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_any;
  logic [WD_W-1:0]     wd_cnt;
  logic                wd_expired;

  logic [NUM_REQ-1:0]  grant_d;
  logic [NUM_REQ-1:0]  done_d;
  logic [NUM_REQ-1:0]  err_d;
  logic                eng_start_d;
  logic                busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  assign wd_expired = (wd_cnt == WD_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; eng_sorted is only looked at in WAIT and beats the
  // watchdog when both land in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (bus.eng_sorted)  state_nxt = DELIVER;
        else if (wd_expired) state_nxt = ABORT;
      end
      DELIVER: state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. done/err are raised
  // on the WAIT exit edge so they are visible exactly while in DELIVER/ABORT.
  always_comb begin
    grant_d     = bus.grant;
    done_d      = '0;
    err_d       = '0;
    eng_start_d = (state == START);
    busy_d      = (state_nxt != IDLE);
    case (state)
      IDLE:    if (pick_any) grant_d = pick_onehot;
      WAIT: begin
        if (bus.eng_sorted)  done_d = bus.grant;
        else if (wd_expired) err_d  = bus.grant;
      end
      DELIVER: grant_d = '0;
      ABORT:   grant_d = '0;
      default: ;
    endcase
  end

  // Output registers, watchdog, table latches and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.err         <= '0;
      bus.eng_start   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.result_data <= '0;
      bus.eng_data_in <= '0;
      rr_ptr          <= '0;
      sel_q           <= '0;
      wd_cnt          <= '0;
    end else begin
      bus.grant     <= grant_d;
      bus.done      <= done_d;
      bus.err       <= err_d;
      bus.eng_start <= eng_start_d;
      bus.busy      <= busy_d;
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel_q           <= pick_sel;
            bus.eng_data_in <= bus.req_data[int'(pick_sel)*TBL_W +: TBL_W];
          end
        end
        START: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (bus.eng_sorted) bus.result_data <= bus.eng_data_out;
        end
        DELIVER, ABORT: begin
          if (sel_q == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
          else                              rr_ptr <= sel_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_engine_arbiter.sv
module tb_sort_engine_arbiter;
  import sort_pkg::*;

  localparam int NREQ = 2;
  localparam int TW   = DEF_TBL_W;
  localparam int TO   = 1023;
  localparam logic [TW-1:0] XMASK = {24{8'h5A}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_engine_arbiter_if #(.NUM_REQ(NREQ), .TBL_W(TW)) bus ();

  sort_engine_arbiter #(
    .NUM_REQ     (NREQ),
    .STRING_LEN  (DEF_STRING_LEN),
    .KEY_BYTES   (DEF_KEY_BYTES),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int eng_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic [TW-1:0]   result;
    int              cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a done/err pulse, then drop the given request bits on that cycle.
  task automatic wait_evt(input logic [NREQ-1:0] drop, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      if ((bus.done | bus.err) != '0) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s_wait: no done/err within %0d cycles, expected one", name, budget);
    end
    bus.req = bus.req & ~drop;
  endtask

  function automatic logic [TW-1:0] mk(input logic [7:0] s);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < DEF_STRING_LEN; e++)
      for (int b = 0; b < DEF_KEY_BYTES; b++)
        t[(e*DEF_KEY_BYTES+b)*8 +: 8] = (b == 0) ? 8'(e) : 8'(s + 8'(e*13 + b));
    return t;
  endfunction

  // Engine model: on eng_start, answer eng_delay cycles later with the
  // captured table xor XMASK. A negative delay models a hung engine.
  initial begin
    logic [TW-1:0] t;
    int d;
    bus.eng_sorted   = 1'b0;
    bus.eng_data_out = '0;
    forever begin
      step();
      if (bus.eng_start && eng_delay >= 0) begin
        t = bus.eng_data_in;
        d = eng_delay;
        repeat (d) step();
        bus.eng_sorted   = 1'b1;
        bus.eng_data_out = t ^ XMASK;
        step();
        bus.eng_sorted   = 1'b0;
        bus.eng_data_out = '0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("onehot", TW'({$onehot0(bus.grant), $onehot0(bus.done), $onehot0(bus.err)}), TW'(3'b111));
        if ((bus.done | bus.err) != '0) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got done=%b err=%b expected none", bus.done, bus.err);
          end else begin
            e = sb.pop_front();
            chk("done", TW'(bus.done), TW'(e.done));
            chk("err", TW'(bus.err), TW'(e.err));
            chk("grant_at_end", TW'(bus.grant), TW'(e.done | e.err));
            chk("result", bus.result_data, e.result);
            chk("pulse_cycle", TW'(cyc), TW'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    logic [TW-1:0] t1, t2a, t2b, t3, t4, t5, t6, t6b;
    int c;
    t1 = mk(8'h11); t2a = mk(8'h22); t2b = mk(8'h33); t3 = mk(8'h44);
    t4 = mk(8'h55); t5 = mk(8'h66); t6 = mk(8'h77); t6b = mk(8'h88);
    bus.req = '0;
    bus.req_data = '0;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_grant", TW'(bus.grant), '0);
    chk("rst_done_err", TW'({bus.done, bus.err}), '0);
    chk("rst_busy_start", TW'({bus.busy, bus.eng_start}), '0);
    chk("rst_result", bus.result_data, '0);
    chk("rst_eng_data_in", bus.eng_data_in, '0);
    rst = 1'b0;

    // 1: single request, engine answers 10 cycles after start
    step();
    eng_delay = 10;
    bus.req_data[0*TW +: TW] = t1;
    bus.req = 2'b01;
    c = cyc;
    sb.push_back('{2'b01, 2'b00, t1 ^ XMASK, c + 13});
    @(negedge clk); chk("t1_busy_c0", TW'(bus.busy), '0);
    @(negedge clk); chk("t1_grant_c1", TW'(bus.grant), TW'(2'b01));
    chk("t1_start_c1", TW'(bus.eng_start), '0);
    chk("t1_busy_c1", TW'(bus.busy), TW'(1));
    @(negedge clk); chk("t1_start_c2", TW'(bus.eng_start), TW'(1));
    chk("t1_eng_data_in", bus.eng_data_in, t1);
    @(negedge clk); chk("t1_start_c3", TW'(bus.eng_start), '0);
    chk("t1_grant_c3", TW'(bus.grant), TW'(2'b01));
    wait_evt(2'b01, 40, "t1");
    @(negedge clk); @(negedge clk);
    chk("t1_busy_after", TW'(bus.busy), '0);
    chk("t1_grant_after", TW'(bus.grant), '0);
    chk("t1_result_held", bus.result_data, t1 ^ XMASK);

    // 3: timeout on requester 1 (rr_ptr is 1 here)
    step();
    eng_delay = -1;
    bus.req_data[1*TW +: TW] = t3;
    bus.req = 2'b10;
    c = cyc;
    sb.push_back('{2'b00, 2'b10, t1 ^ XMASK, c + 3 + TO});
    @(negedge clk); @(negedge clk); chk("t3_grant", TW'(bus.grant), TW'(2'b10));
    wait_evt(2'b10, TO + 20, "t3");
    @(negedge clk); @(negedge clk);
    chk("t3_busy_after", TW'(bus.busy), '0);
    chk("t3_result_unchanged", bus.result_data, t1 ^ XMASK);

    // 2: both held with rr_ptr=0 -> 01, 10, 01
    step();
    eng_delay = 3;
    bus.req_data[0*TW +: TW] = t2a;
    bus.req_data[1*TW +: TW] = t2b;
    bus.req = 2'b11;
    c = cyc;
    sb.push_back('{2'b01, 2'b00, t2a ^ XMASK, c + 6});
    sb.push_back('{2'b10, 2'b00, t2b ^ XMASK, c + 13});
    sb.push_back('{2'b01, 2'b00, t2a ^ XMASK, c + 20});
    @(negedge clk); @(negedge clk); chk("t2_grant0", TW'(bus.grant), TW'(2'b01));
    wait_evt(2'b00, 30, "t2a");
    @(negedge clk); @(negedge clk); chk("t2_gap", TW'(bus.grant), '0);
    @(negedge clk); chk("t2_grant1", TW'(bus.grant), TW'(2'b10));
    wait_evt(2'b00, 30, "t2b");
    wait_evt(2'b11, 30, "t2c");

    // 4: eng_sorted lands on the watchdog limit; done must win
    step();
    eng_delay = TO;
    bus.req_data[0*TW +: TW] = t4;
    bus.req = 2'b01;
    c = cyc;
    sb.push_back('{2'b01, 2'b00, t4 ^ XMASK, c + 3 + TO});
    wait_evt(2'b01, TO + 20, "t4");
    @(negedge clk); @(negedge clk);
    chk("t4_busy_after", TW'(bus.busy), '0);

    // 5: table and req change during WAIT are ignored
    step();
    eng_delay = 8;
    bus.req_data[0*TW +: TW] = t5;
    bus.req = 2'b01;
    c = cyc;
    sb.push_back('{2'b01, 2'b00, t5 ^ XMASK, c + 11});
    repeat (5) step();
    bus.req_data[0*TW +: TW] = ~t5;
    bus.req = 2'b00;
    step();
    @(negedge clk);
    chk("t5_eng_data_in", bus.eng_data_in, t5);
    chk("t5_grant", TW'(bus.grant), TW'(2'b01));
    wait_evt(2'b00, 20, "t5");

    // 6: reset mid-WAIT, late engine pulse in IDLE, then restart with rr_ptr=0
    step();
    eng_delay = 20;
    bus.req_data[0*TW +: TW] = t6;
    bus.req = 2'b01;
    repeat (6) step();
    rst = 1'b1;
    bus.req = 2'b00;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_grant", TW'(bus.grant), '0);
    chk("t6_busy", TW'(bus.busy), '0);
    chk("t6_start", TW'(bus.eng_start), '0);
    chk("t6_result", bus.result_data, '0);
    chk("t6_eng_data_in", bus.eng_data_in, '0);
    repeat (30) step();
    @(negedge clk);
    chk("t6_idle_after_spurious", TW'(bus.busy), '0);
    step();
    eng_delay = 4;
    bus.req_data[0*TW +: TW] = t6b;
    bus.req_data[1*TW +: TW] = t3;
    bus.req = 2'b11;
    c = cyc;
    sb.push_back('{2'b01, 2'b00, t6b ^ XMASK, c + 7});
    @(negedge clk); @(negedge clk); chk("t6_restart_grant", TW'(bus.grant), TW'(2'b01));
    wait_evt(2'b11, 30, "t6");

    repeat (3) step();
    chk("sb_empty", TW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
